uart_mm_host: RTL
=================

UART_MM_HOST -- requirements
Module: uart_mm_host

Interface
REQ-001 Parameter NUM_BYTES_DATA, default 4, is the data word width in bytes.
REQ-002 Parameter NUM_BYTES_ADDRESS, default 1, is the address width in bytes.
REQ-003 Parameter CLKS_PER_BIT, default 434, is the number of clk cycles per UART bit (50 MHz / 115200).
REQ-004 Parameter RESP_TIMEOUT, default 100000, is the number of clk cycles allowed for a response.
REQ-005 Port clk  in  1  is the single clock; all logic is on its rising edge.
REQ-006 Port rst  in  1  is the synchronous, active-high reset.
REQ-007 Port req_valid  in  1  indicates that a request is offered.
REQ-008 Port req_ready  out  1  indicates that the block accepts a request.
REQ-009 Port req_we  in  1  selects the command: 1 is write, 0 is read.
REQ-010 Port req_addr  in  NUM_BYTES_ADDRESS*8  is the target address.
REQ-011 Port req_wdata  in  NUM_BYTES_DATA*8  is the write data.
REQ-012 Port rsp_valid  out  1  is a one-cycle completion pulse.
REQ-013 Port rsp_rdata  out  NUM_BYTES_DATA*8  is the read data; it is valid with rsp_valid for reads.
REQ-014 Port rsp_err  out  1  is qualified by rsp_valid and flags a timeout, framing error or bad acknowledge.
REQ-015 Port rx  in  1  is the serial input from the memory-mapped UART target.
REQ-016 Port tx  out  1  is the serial output to the target.

Function
REQ-017 A request SHALL transfer when req_valid and req_ready are both 1 on a clock edge; the block SHALL register req_we, req_addr and req_wdata at that edge.
REQ-018 req_ready SHALL be 1 only in state IDLE.
REQ-019 The block SHALL use states IDLE -> SEND -> WAIT_RSP -> DONE -> IDLE.
REQ-020 The request frame SHALL be: opcode byte (0x57 for write, 0x52 for read), then the address bytes LSB first, then, for writes only, the data bytes LSB first.
REQ-021 Each byte SHALL be sent 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-022 Consecutive frame bytes SHALL be sent back-to-back with no idle bit between them.
REQ-023 The first start bit SHALL begin on the cycle after acceptance.
REQ-024 SEND SHALL leave for WAIT_RSP at the end of the last stop bit.
REQ-025 The write response SHALL be one byte; 0x41 is success and any other value SHALL set rsp_err.
REQ-026 The read response SHALL be NUM_BYTES_DATA bytes, LSB first, assembled into rsp_rdata.
REQ-027 The receiver SHALL pass rx through a 2-flop synchronizer and SHALL detect a start bit on a 1->0 transition of the synchronized signal.
REQ-028 The receiver SHALL re-check the start bit at CLKS_PER_BIT/2 and SHALL return to hunting if that sample is 1 (glitch rejection).
REQ-029 The receiver SHALL sample each data bit and the stop bit at its bit centre.
REQ-030 A stop bit sampled as 0 SHALL set rsp_err and SHALL end WAIT_RSP immediately.
REQ-031 The timeout counter SHALL start on entry to WAIT_RSP and SHALL reset on each received byte.
REQ-032 When the timeout counter reaches RESP_TIMEOUT, the block SHALL go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-033 In DONE, rsp_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-034 A response is complete on the cycle its last stop-bit sample is taken.
REQ-035 rx activity outside WAIT_RSP SHALL be ignored.
REQ-036 A new request presented while busy SHALL be ignored, because req_ready=0.
REQ-037 rsp_rdata SHALL hold its value until the next response.

Reset
REQ-038 While rst=1, the block SHALL set: state IDLE, tx=1, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and all counters 0.
REQ-039 req_ready SHALL become 1 on the first cycle after rst is released.
REQ-040 A reset asserted mid-frame SHALL drive tx=1 on the next cycle, abandon the transaction and produce no rsp_valid.

Structure
REQ-041 Package uart_mm_pkg SHALL hold: the opcode constants OP_WRITE=8'h57 and OP_READ=8'h52, the constant ACK=8'h41, and the state enum typedef.
REQ-042 The receive path SHALL be the sub-module uart_mm_rx_byte (synchronizer, centre sampling, output byte valid and framing error); the transmit path and the FSM stay inline.

Verification
REQ-043 CLKS_PER_BIT=4; write request addr=0x12, wdata=0xDEADBEEF -> tx carries bytes 57 12 EF BE AD DE; 0x41 is then driven on rx -> one rsp_valid pulse with rsp_err=0.
REQ-044 Read request addr=0x05; rx returns 78 56 34 12 -> rsp_rdata=0x12345678 with rsp_err=0.
REQ-045 Read request with rx held at 1 and RESP_TIMEOUT=200 -> rsp_valid with rsp_err=1 exactly 200 cycles after the end of the last stop bit.
REQ-046 Write request answered with rx byte 0x4E -> rsp_err=1; a read response whose second byte has stop bit 0 -> rsp_err=1.
REQ-047 rst asserted during the address byte -> tx=1 on the next cycle, no rsp_valid, and a request is accepted on the first cycle after release.
REQ-048 A 1-cycle low glitch on rx in WAIT_RSP -> no byte received, and the timeout counter does not restart.

Source files
------------

// File: rtl/uart_mm_pkg.sv
// Shared constants and state types for the UART memory-mapped host.
package uart_mm_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK      = 8'h41;

    typedef enum logic [1:0] {StIdle, StSend, StWaitRsp, StDone} state_e;

    typedef enum logic [1:0] {RxHunt, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_mm_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, glitch-checked start bit, centre sampling.
module uart_mm_rx_byte
    import uart_mm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     st_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            st_q        <= RxHunt;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            byte_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_o <= 1'b0;
            if (!en_i) begin
                st_q  <= RxHunt;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                unique case (st_q)
                    RxHunt: begin
                        cnt_q <= '0;
                        if (prev_q && !sync2_q) st_q <= RxStart;
                    end
                    RxStart: begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (cnt_q == HALF_LAST) begin
                            cnt_q <= '0;
                            idx_q <= '0;
                            st_q  <= sync2_q ? RxHunt : RxData;
                        end
                    end
                    RxData: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q <= '0;
                            sh_q  <= {sync2_q, sh_q[7:1]};
                            idx_q <= idx_q + 1'b1;
                            if (idx_q == 3'd7) st_q <= RxStop;
                        end
                    end
                    RxStop: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q       <= '0;
                            st_q        <= RxHunt;
                            byte_o      <= sh_q;
                            valid_o     <= 1'b1;
                            frame_err_o <= !sync2_q;
                        end
                    end
                    default: st_q <= RxHunt;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_mm_host.sv
// Host that turns read/write requests into UART command frames and collects the reply.
module uart_mm_host
    import uart_mm_pkg::*;
#(
    parameter int unsigned NUM_BYTES_DATA    = 4,
    parameter int unsigned NUM_BYTES_ADDRESS = 1,
    parameter int unsigned CLKS_PER_BIT      = 434,
    parameter int unsigned RESP_TIMEOUT      = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] req_addr,
    input  logic [NUM_BYTES_DATA*8-1:0]    req_wdata,
    output logic                          rsp_valid,
    output logic [NUM_BYTES_DATA*8-1:0]    rsp_rdata,
    output logic                          rsp_err,
    input  logic                          rx,
    output logic                          tx
);

    localparam int unsigned DW  = NUM_BYTES_DATA * 8;
    localparam int unsigned FW  = 8 + NUM_BYTES_ADDRESS * 8 + DW;
    localparam int unsigned CW  = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TW  = $clog2(RESP_TIMEOUT + 1);
    localparam int unsigned NBW = $clog2(NUM_BYTES_ADDRESS + NUM_BYTES_DATA + 2);
    localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(RESP_TIMEOUT - 1);
    localparam logic [NBW-1:0] WR_LAST  = NBW'(NUM_BYTES_ADDRESS + NUM_BYTES_DATA);
    localparam logic [NBW-1:0] RD_LAST  = NBW'(NUM_BYTES_ADDRESS);
    localparam logic [NBW-1:0] RSP_LAST = NBW'(NUM_BYTES_DATA - 1);

    state_e         state_q;
    logic           we_q;
    logic [FW-1:0]  frame_q;
    logic [CW-1:0]  clk_cnt_q;
    logic [3:0]     bit_idx_q;
    logic [NBW-1:0] byte_idx_q;
    logic [TW-1:0]  tmo_q;
    logic [DW-1:0]  rdata_sh_q;

    logic          rx_en, rx_valid, rx_frame_err;
    logic [7:0]    rx_byte;
    logic [DW-1:0] rx_next;

    assign rx_en   = (state_q == StWaitRsp);
    assign rx_next = DW'({rx_byte, rdata_sh_q} >> 8);

    uart_mm_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .en_i       (rx_en),
        .rx_i       (rx),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .frame_err_o(rx_frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_ready  <= 1'b0;
            tx         <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            we_q       <= 1'b0;
            frame_q    <= '0;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tmo_q      <= '0;
            rdata_sh_q <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        we_q       <= req_we;
                        frame_q    <= {req_wdata, req_addr, req_we ? OP_WRITE : OP_READ};
                        tx         <= 1'b0;
                        clk_cnt_q  <= '0;
                        bit_idx_q  <= '0;
                        byte_idx_q <= '0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    clk_cnt_q <= clk_cnt_q + 1'b1;
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == 4'd9) begin
                            bit_idx_q <= '0;
                            if (byte_idx_q == (we_q ? WR_LAST : RD_LAST)) begin
                                state_q    <= StWaitRsp;
                                byte_idx_q <= '0;
                                tmo_q      <= '0;
                            end else begin
                                // Next start bit follows the stop bit directly.
                                byte_idx_q <= byte_idx_q + 1'b1;
                                frame_q    <= frame_q >> 8;
                                tx         <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx        <= (bit_idx_q == 4'd8) ? 1'b1 : frame_q[bit_idx_q[2:0]];
                        end
                    end
                end
                StWaitRsp: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (rx_valid) begin
                        tmo_q <= '0;
                        if (rx_frame_err) begin
                            state_q   <= StDone;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (we_q) begin
                            state_q   <= StDone;
                            rsp_valid <= 1'b1;
                            rsp_err   <= (rx_byte != ACK);
                        end else if (byte_idx_q == RSP_LAST) begin
                            state_q   <= StDone;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= rx_next;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            rdata_sh_q <= rx_next;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q   <= StDone;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
